// File: rtl/fp8_pkg.sv
// Shared constants and types for the BF16 -> FP8 E4M3 operand feeder.
package fp8_pkg;
  localparam int BF16_W     = 16;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int E4M3_W     = 8;
  localparam int E4M3_EXP_W = 4;
  localparam int E4M3_MAN_W = 3;
  localparam int E4M3_BIAS  = 7;
  localparam int BF16_BIAS  = 127;
  localparam logic [6:0] E4M3_MAX_MAG = 7'h7F;

  typedef struct packed {
    logic [E4M3_W-1:0] code;
    logic              saturated;
  } e4m3_res_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } drain_state_t;
endpackage

// File: rtl/bf16_to_e4m3.sv
// Combinational BF16 -> E4M3 (bias 7, no NaN/Inf codes) with round-to-nearest-even
// and saturation to +/-480.
module bf16_to_e4m3
  import fp8_pkg::*;
(
  input  logic [BF16_W-1:0] bf16_in,
  output e4m3_res_t         res
);
  localparam logic signed [9:0] BIAS_DIFF = 10'(BF16_BIAS - E4M3_BIAS);

  logic                  sgn;
  logic [BF16_EXP_W-1:0] exp_b;
  logic [BF16_MAN_W-1:0] man_b;
  logic signed [9:0]     e4;
  logic signed [9:0]     e_rnd;
  logic [9:0]            nsh;
  logic [16:0]           shifted;
  logic [E4M3_MAN_W:0]   mant_rnd;
  logic                  guard;
  logic                  sticky;
  logic                  rnd_up;

  always_comb begin
    sgn           = bf16_in[15];
    exp_b         = bf16_in[14:7];
    man_b         = bf16_in[6:0];
    e4            = $signed({2'b00, exp_b}) - BIAS_DIFF;
    e_rnd         = '0;
    nsh           = '0;
    shifted       = '0;
    mant_rnd      = '0;
    guard         = 1'b0;
    sticky        = 1'b0;
    rnd_up        = 1'b0;
    res.code      = {sgn, 7'h00};
    res.saturated = 1'b0;

    if (exp_b == '0) begin
      res.code = {sgn, 7'h00};
    end else if (exp_b == '1) begin
      // NaN loses its sign; Inf keeps it. Both clip to the largest magnitude.
      res.saturated = 1'b1;
      res.code      = (man_b == '0) ? {sgn, E4M3_MAX_MAG} : {1'b0, E4M3_MAX_MAG};
    end else if (e4 > 10'sd0) begin
      guard    = man_b[3];
      sticky   = |man_b[2:0];
      rnd_up   = guard & (sticky | man_b[4]);
      mant_rnd = {1'b0, man_b[6:4]} + {3'b000, rnd_up};
      e_rnd    = e4 + $signed({9'b0, mant_rnd[E4M3_MAN_W]});
      if (e_rnd > 10'sd15) begin
        res.saturated = 1'b1;
        res.code      = {sgn, E4M3_MAX_MAG};
      end else begin
        res.code = {sgn, e_rnd[E4M3_EXP_W-1:0], mant_rnd[E4M3_MAN_W-1:0]};
      end
    end else begin
      // Subnormal: {1,M} shifted right by 1-e4; bits [16:14] are the mantissa,
      // bit 13 the guard. A rounding carry lands in the exponent LSB.
      nsh = -e4;
      if (nsh < 10'd9) begin
        shifted  = {1'b1, man_b, 9'b0} >> nsh;
        guard    = shifted[13];
        sticky   = |shifted[12:0];
        rnd_up   = guard & (sticky | shifted[14]);
        mant_rnd = {1'b0, shifted[16:14]} + {3'b000, rnd_up};
        res.code = {sgn, 3'b000, mant_rnd};
      end
    end
  end
endmodule

// File: rtl/bf16_fp8_feeder.sv
// Systolic-edge feeder: accepts LANES BF16 operands per beat, quantises to E4M3,
// skews lane i by i cycles, and signals done once a tile has fully drained.
module bf16_fp8_feeder
  import fp8_pkg::*;
#(
  parameter int LANES = 4,
  parameter int SATW  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*LANES-1:0] in_data,
  input  logic                in_last,
  output logic [8*LANES-1:0]  fp8_out,
  output logic [LANES-1:0]    lane_valid,
  output logic                done,
  output logic [SATW-1:0]     sat_count
);
  localparam int CW = $clog2(LANES + 2);
  localparam int PW = $clog2(LANES + 1);

  logic                accept;
  logic [16*LANES-1:0] data_p1_d, data_p1_q;
  logic                vld_p1_d, vld_p1_q;
  e4m3_res_t           res [LANES];
  logic [PW-1:0]       sat_lanes;
  logic [SATW:0]       sat_sum;
  logic [SATW-1:0]     sat_count_d, sat_count_q;
  drain_state_t        state_d, state_q;
  logic [CW-1:0]       cnt_d, cnt_q;
  logic                done_d, done_q;

  assign in_ready  = (state_q != ST_DRAIN);
  assign accept    = in_valid && in_ready;
  assign done      = done_q;
  assign sat_count = sat_count_q;

  always_comb begin
    data_p1_d = accept ? in_data : data_p1_q;
    vld_p1_d  = accept;
    sat_lanes = '0;
    for (int i = 0; i < LANES; i++) sat_lanes = sat_lanes + PW'(res[i].saturated);
    sat_sum     = {1'b0, sat_count_q} + (SATW+1)'(sat_lanes);
    sat_count_d = sat_count_q;
    if (vld_p1_q) sat_count_d = sat_sum[SATW] ? '1 : sat_sum[SATW-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_STREAM: begin
        if (accept) begin
          if (in_last) begin
            state_d = ST_DRAIN;
            cnt_d   = CW'(LANES);
          end else begin
            state_d = ST_STREAM;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_STREAM;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // S1: accepted beat; also control state and saturation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1_q   <= '0;
      vld_p1_q    <= 1'b0;
      sat_count_q <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      data_p1_q   <= data_p1_d;
      vld_p1_q    <= vld_p1_d;
      sat_count_q <= sat_count_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [i:0][7:0] byte_d, byte_q;
    logic [i:0]      vld_d, vld_q;

    bf16_to_e4m3 u_cvt (
      .bf16_in (data_p1_q[16*i +: 16]),
      .res     (res[i])
    );

    // S2 is entry 0; entries 1..i form this lane's skew chain
    always_comb begin
      byte_d[0] = res[i].code;
      vld_d[0]  = vld_p1_q;
      for (int k = 1; k <= i; k++) begin
        byte_d[k] = byte_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        byte_q <= '0;
        vld_q  <= '0;
      end else begin
        byte_q <= byte_d;
        vld_q  <= vld_d;
      end
    end

    assign fp8_out[8*i +: 8] = vld_q[i] ? byte_q[i] : 8'h00;
    assign lane_valid[i]     = vld_q[i];
  end
endmodule
